seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Multiplexed multi-digit seven-segment display driver: latches a packed hex value, then time-division scans it onto one shared active-low segment bus with one-hot active-low digit enables. Adds leading-zero suppression, per-digit blanking, decimal points and anti-ghosting guard intervals. Sits between datapath/debug registers and the board display pins, replacing per-digit combinational hex decoders.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥1)
- CLK_DIV, 100000, clock cycles each digit is held (≥2)
- GUARD, 4, cycles at the start of each digit slot with all enables off (0 ≤ GUARD < CLK_DIV)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- value  in  4*NUM_DIGITS  packed nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 = least significant)
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- load  in  1  when 1 at a clock edge, value and dp_in are captured
- lz_blank  in  1  leading-zero suppression enable (live, not latched)
- blank_mask  in  NUM_DIGITS  1 = force digit i dark (live, not latched)
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit enables, active-low, at most one low
- frame_tick  out  1  one-cycle pulse at start of each full scan

## Operation
- State: slot counter cnt (0..CLK_DIV-1), digit index idx (0..NUM_DIGITS-1, width max(1,$clog2(NUM_DIGITS))), latched val_q, dp_q.
- Every cycle: cnt==CLK_DIV-1 → cnt=0, idx=(idx==NUM_DIGITS-1)?0:idx+1; else cnt+1.
- load=1 → val_q=value, dp_q=dp_in. Scan position unaffected.
- Glyph decode of nibble (a..g, 0=on): 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- Digit i is dark if blank_mask[i]=1, or lz_blank=1 and i≠0 and nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never lz-blanked (value 0 shows "0").
- Dark digit: seg=1111111, dp=1; its enable still follows the scan.
- Lit digit: seg=decode(val_q nibble idx), dp=~dp_q[idx].
- Enables: cnt<GUARD → an all ones; else an=~(1<<idx).

## Timing
- seg, dp, an, frame_tick are registered from current cnt/idx/val_q/dp_q/lz_blank/blank_mask: one cycle latency.
- frame_tick registered from (cnt==CLK_DIV-1 && idx==NUM_DIGITS-1): high during first cycle of digit 0's slot.
- Reset (rst_n=0 at edge): cnt=0, idx=0, val_q=0, dp_q=0, seg=1111111, dp=1, an=all ones, frame_tick=0. Applies mid-scan identically.
- Load at edge k visible on seg/dp after edge k+1. Load coinciding with slot change: new slot uses new value.
- Full frame = NUM_DIGITS*CLK_DIV cycles; idx wraps NUM_DIGITS-1→0 without gap.
- GUARD=0: no dark interval, an changes in the same cycle as seg.
- lz_blank/blank_mask changes take effect after one edge, mid-slot permitted.

## Test plan
(NUM_DIGITS=4, CLK_DIV=8, GUARD=2)
- Reset: rst_n=0 3 cycles → seg=1111111, dp=1, an=1111, frame_tick=0; after release an=1111 for 2 edges, an=1110 from 3rd edge, seg=0000001.
- load value=16'h12AF, dp_in=4'b0100 → slot seg/an: 0111000/1110, 0001000/1101, 0010010/1011 with dp=0, 1001111/0111; dp=1 elsewhere.
- lz_blank=1, value=16'h0030 → digits 3,2 seg=1111111; digit 1 0000110; digit 0 0000001. value=0 → only digit 0 lit with 0000001.
- blank_mask=4'b0010, value=16'h8888, dp_in=4'b1111 → digit 1 seg=1111111, dp=1, an=1101 still asserted; others 0000000, dp=0.
- frame_tick: exactly one pulse every 32 cycles, coincident with an=1111 guard of digit 0 slot; in reset never asserted.
- Mid-slot load (during digit 2, value 16'h0500→16'h0700) → seg 0100100→0001111 one edge after capture edge, an unchanged; rst_n low mid-slot → reset values next edge, scan restarts at digit 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed multi-digit seven-segment driver
// latches a packed hex value and time-division scans it onto shared pins
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   value       packed nibbles, nibble i drives digit i (captured on load)
//   dp_in       decimal point request per digit (captured on load)
//   load        capture strobe for value and dp_in
//   lz_blank    leading-zero suppression enable (live)
//   blank_mask  1 forces the digit dark (live)
//   seg         segments a..g, active-low, seg[6]=a
//   dp          decimal point, active-low
//   an          digit enables, active-low, at most one low
//   frame_tick  one-cycle pulse at the start of each full scan
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int GUARD      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    zero_run;
    logic                    lz_dark;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    assign cur_nib = val_q[{idx, 2'b00} +: 4];
    assign cur_dp  = dp_q[idx];

    // upper_zero[i]: nibbles NUM_DIGITS-1 down to i are all zero
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (val_q[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    // digit 0 is exempt so an all-zero value still shows "0"
    assign lz_dark = lz_blank && (idx != '0) && upper_zero[idx];
    assign dark    = blank_mask[idx] || lz_dark;

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_comb begin
        seg_next = dark ? 7'b1111111 : decode(cur_nib);
        dp_next  = dark ? 1'b1 : ~cur_dp;
        // leading guard cycles keep every enable off to avoid ghosting
        an_next  = (cnt < GUARD_C) ? '1 : ~onehot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            val_q      <= '0;
            dp_q       <= '0;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                val_q <= value;
                dp_q  <= dp_in;
            end
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: scoreboard bench for seven_segment_scanner
// directed display scenarios followed by randomized traffic and resets
module tb_seven_segment_scanner;

    localparam int N     = 4;
    localparam int CD    = 8;
    localparam int G     = 2;
    localparam int FRAME = N * CD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4*N-1:0]   value;
    logic [N-1:0]     dp_in;
    logic             load;
    logic             lz_blank;
    logic [N-1:0]     blank_mask;
    logic [6:0]       seg;
    logic             dp;
    logic [N-1:0]     an;
    logic             frame_tick;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         ft;
    } exp_t;

    exp_t q[$];
    int   errors  = 0;
    int   checks  = 0;
    bit   started = 1'b0;
    int   pos     = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_segment_scanner #(
        .NUM_DIGITS(N),
        .CLK_DIV(CD),
        .GUARD(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .dp_in(dp_in),
        .load(load),
        .lz_blank(lz_blank),
        .blank_mask(blank_mask),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference model: scan position is a plain frame offset, digit and
    // slot offset come from division; leading zeros from the top nonzero
    initial begin
        logic [4*N-1:0] m_val;
        logic [N-1:0]   m_dp;
        exp_t           e;
        int             d;
        int             off;
        int             hi;
        bit             dk;
        m_val = '0;
        m_dp  = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
                e.an  = '1;
                e.ft  = 1'b0;
                pos   = 0;
                m_val = '0;
                m_dp  = '0;
            end else begin
                d   = pos / CD;
                off = pos % CD;
                hi  = -1;
                for (int i = 0; i < N; i++)
                    if (m_val[4*i +: 4] != 4'h0) hi = i;
                dk = blank_mask[d] || (lz_blank && d != 0 && d > hi);
                e.seg = dk ? 7'b1111111 : glyph[m_val[4*d +: 4]];
                e.dp  = dk ? 1'b1 : !m_dp[d];
                e.an  = (off < G) ? '1 : ~(N'(1) << d);
                e.ft  = (pos == FRAME - 1);
                pos   = (pos + 1) % FRAME;
                if (load) begin
                    m_val = value;
                    m_dp  = dp_in;
                end
            end
            q.push_back(e);
            started = 1'b1;
        end
    end

    // monitor: outputs settle after posedge, compared on negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (q.size() == 0) begin
                    chk("queue_empty", 8'd0, 8'd1);
                end else begin
                    e = q.pop_front();
                    chk("seg", {1'b0, seg}, {1'b0, e.seg});
                    chk("dp", {7'b0, dp}, {7'b0, e.dp});
                    chk("an", {4'b0, an}, {4'b0, e.an});
                    chk("frame_tick", {7'b0, frame_tick}, {7'b0, e.ft});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] p);
        value = v;
        dp_in = p;
        load  = 1'b1;
        cycles(1);
        load  = 1'b0;
    endtask

    // bounded wait for a given frame offset in the model
    task automatic wait_pos(input int target);
        int k;
        k = 0;
        while (pos != target && k < 4 * FRAME) begin
            cycles(1);
            k++;
        end
        if (pos != target) chk("wait_pos_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        logic [15:0] r;
        rst_n      = 1'b0;
        value      = '0;
        dp_in      = '0;
        load       = 1'b0;
        lz_blank   = 1'b0;
        blank_mask = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        do_load(16'h12AF, 4'b0100);
        cycles(2 * FRAME);

        lz_blank = 1'b1;
        do_load(16'h0030, 4'b0000);
        cycles(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        cycles(2 * FRAME);
        lz_blank = 1'b0;

        blank_mask = 4'b0010;
        do_load(16'h8888, 4'b1111);
        cycles(2 * FRAME);
        blank_mask = 4'b0000;

        do_load(16'h0500, 4'b0000);
        wait_pos(2 * CD + 3);
        do_load(16'h0700, 4'b0000);
        cycles(FRAME);

        wait_pos(CD + 5);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(2 * FRAME);

        for (int i = 0; i < 3000; i++) begin
            r     = 16'($urandom);
            value = r >> (4 * $urandom_range(0, 4));
            dp_in = N'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0)
                lz_blank = 1'($urandom);
            if ($urandom_range(0, 47) == 0)
                blank_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rst_n = ($urandom_range(0, 399) != 0);
            cycles(1);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
